minterm_sweep_ctrl: RTL

//   Upstream sequencer and capture stage for the decoder-based 3-input function generator.
//   On start it drives the generator's select input through every minterm, 0 .. 2**WIDTH-1.
//   It holds each code long enough for the combinational outputs to settle, then samples f1/f2/f3.
//   It builds one truth-table word per function and flags any deviation from the expected minterm masks.

---
 rtl/minterm_sweep_if.sv | 31 +++
 rtl/minterm_sweep_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/minterm_sweep_if.sv
// minterm_sweep_if: bundle between the sweep controller (master) and its user/generator side (slave)
//   start         sweep request
//   f1..f3        function-generator outputs fed back for capture
//   in            select code driven to the generator
//   busy, done    sweep status; done is a one-cycle completion pulse
//   tt_f1..tt_f3  captured truth tables, bit i = value at code i
//   mismatch      sticky deviation flag against the expected masks
interface minterm_sweep_if #(
    parameter int WIDTH = 3
);
    localparam int N = 2 ** WIDTH;
    logic             start;
    logic             f1;
    logic             f2;
    logic             f3;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
    logic [N-1:0]     tt_f1;
    logic [N-1:0]     tt_f2;
    logic [N-1:0]     tt_f3;
    logic             mismatch;
    modport master (
        input  start, f1, f2, f3,
        output in, busy, done, tt_f1, tt_f2, tt_f3, mismatch
    );
    modport slave (
        output start, f1, f2, f3,
        input  in, busy, done, tt_f1, tt_f2, tt_f3, mismatch
    );
endinterface

// File: rtl/minterm_sweep_ctrl.sv
// minterm_sweep_ctrl: steps a select code through every minterm, captures f1..f3 truth tables, flags deviations
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    minterm_sweep_if master: start/f1..f3 in; in/busy/done/tt_f1..3/mismatch out
module minterm_sweep_ctrl #(
    parameter int                    WIDTH  = 3,
    parameter int                    SETTLE = 2,
    parameter logic [2**WIDTH-1:0]   EXP_F1 = 8'b1010_0010,
    parameter logic [2**WIDTH-1:0]   EXP_F2 = 8'b1011_1001,
    parameter logic [2**WIDTH-1:0]   EXP_F3 = 8'b1000_1010
) (
    input logic          clk,
    input logic          reset,
    minterm_sweep_if.master bus
);
    localparam int N  = 2 ** WIDTH;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] CODE_LAST = WIDTH'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bus.in       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.tt_f1    <= '0;
            bus.tt_f2    <= '0;
            bus.tt_f3    <= '0;
            bus.mismatch <= 1'b0;
        end else begin
            case (state)
                // DONE behaves like IDLE so a held start chains sweeps back to back
                S_IDLE, S_DONE: begin
                    bus.done <= 1'b0;
                    state    <= S_IDLE;
                    if (bus.start) begin
                        state        <= S_SETTLE;
                        cnt          <= '0;
                        bus.in       <= '0;
                        bus.busy     <= 1'b1;
                        bus.tt_f1    <= '0;
                        bus.tt_f2    <= '0;
                        bus.tt_f3    <= '0;
                        bus.mismatch <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    bus.tt_f1[bus.in] <= bus.f1;
                    bus.tt_f2[bus.in] <= bus.f2;
                    bus.tt_f3[bus.in] <= bus.f3;
                    bus.mismatch <= bus.mismatch | (bus.f1 != EXP_F1[bus.in])
                                  | (bus.f2 != EXP_F2[bus.in]) | (bus.f3 != EXP_F3[bus.in]);
                    if (bus.in == CODE_LAST) begin
                        state    <= S_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state  <= S_SETTLE;
                        bus.in <= bus.in + 1'b1;
                        cnt    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
